// File: rtl/mem_pkg.sv
// mem_pkg: shared state encodings, default sizes and sizing helpers for mem_bank_hs
package mem_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH = 256;
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: zero-initialised word storage with combinational read and byte-masked clocked write
module mem_array import mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = idx_w(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [AW-1:0]              addr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [lanes(DATA_W)-1:0]   be,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  assign rdata = mem[addr];
  // Only lanes with their byte enable set take the new data.
  always_ff @(posedge clk)
    for (int i = 0; i < lanes(DATA_W); i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/mem_bank_hs.sv
// mem_bank_hs: handshaked single-port memory with programmable wait states and range checking
module mem_bank_hs import mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [lanes(DATA_W)-1:0]  req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);
  localparam int AW = idx_w(DEPTH);
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q, addr_sel;
  logic wr_q, wr_sel, accept, in_range, enter_resp;
  logic [DATA_W-1:0] rdata;
  assign req_ready = state == ST_IDLE && !rst;
  assign rsp_valid = state == ST_RESP;
  assign accept = req_valid && req_ready;
  assign addr_sel = state == ST_IDLE ? req_addr : addr_q;
  assign wr_sel = state == ST_IDLE ? req_wr : wr_q;
  assign in_range = 32'(addr_sel) < DEPTH;
  assign enter_resp = state != ST_RESP && state_n == ST_RESP;
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (accept && req_wr && in_range),
    .addr  (addr_sel[AW-1:0]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (rdata)
  );
  // Next-state: accept from IDLE, count out the wait states, hold RESP until consumed.
  always_comb begin
    state_n = state;
    state_n = state == ST_IDLE ? (accept ? (WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT) : ST_IDLE)
            : state == ST_WAIT ? (cnt == WLAST ? ST_RESP : ST_WAIT)
            : state == ST_RESP ? (rsp_ready ? ST_IDLE : ST_RESP) : ST_IDLE;
  end
  // State, wait counter, request latches and the response registers loaded on entry to RESP.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == ST_WAIT ? cnt + 4'd1 : '0;
      if (accept) begin
        addr_q <= req_addr;
        wr_q <= req_wr;
      end
      if (enter_resp) begin
        rsp_err <= !in_range;
        rsp_rdata <= (wr_sel || !in_range) ? '0 : rdata;
      end
    end
endmodule
